ctrl_sched_loader: RTL

Host-side transmitter for the BDF schedule controller. It accepts a schedule of `ITER_PERIOD` control words over a valid/ready stream and replays them into the controller's load port as `load_ctrl`/`ctrl_in` pulses. It then sequences `start_ctrl`/`stop_ctrl` for a programmed number of iterations, or runs free until aborted. It sits between the host or testbench and `controller`, and drives every controller input except `clk`/`rst`.

---
 rtl/ctrl_sched_loader_if.sv | 40 ++++
 rtl/ctrl_sched_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ctrl_sched_loader_if.sv
// Host-side bundle for ctrl_sched_loader: schedule stream, run commands, controller drive and status.
// Latency: none (wires only).
// Backpressure: s_valid/s_ready stream; commands are single-cycle pulses with no handshake.
interface ctrl_sched_loader_if #(
  parameter int CTRL_WIDTH     = 24,
  parameter int ITER_CNT_WIDTH = 16
);
  // Host schedule stream
  logic                      s_valid;
  logic                      s_ready;
  logic [CTRL_WIDTH-1:0]     s_data;
  // Run commands
  logic                      cmd_run;
  logic [ITER_CNT_WIDTH-1:0] run_iters;
  logic                      cmd_abort;
  // Controller drive
  logic                      load_ctrl;
  logic [CTRL_WIDTH-1:0]     ctrl_in;
  logic                      start_ctrl;
  logic                      stop_ctrl;
  // Status
  logic                      sched_loaded;
  logic                      busy;
  logic                      iter_done;
  logic [ITER_CNT_WIDTH-1:0] iter_count;

  // Host / testbench side
  modport master (
    output s_valid, s_data, cmd_run, run_iters, cmd_abort,
    input  s_ready, load_ctrl, ctrl_in, start_ctrl, stop_ctrl,
           sched_loaded, busy, iter_done, iter_count
  );

  // Loader side
  modport slave (
    input  s_valid, s_data, cmd_run, run_iters, cmd_abort,
    output s_ready, load_ctrl, ctrl_in, start_ctrl, stop_ctrl,
           sched_loaded, busy, iter_done, iter_count
  );
endinterface

// File: rtl/ctrl_sched_loader.sv
// Loads an ITER_PERIOD-word schedule into the BDF controller, then sequences start/stop for N iterations or free-run.
// Latency: 1 cycle from s_valid&&s_ready to load_ctrl/ctrl_in, and from cmd_run/cmd_abort to start_ctrl/stop_ctrl.
// Backpressure: s_ready is high only in LOAD; it drops the cycle after the last word and returns after an abort in ARMED.
module ctrl_sched_loader #(
  parameter int CTRL_WIDTH     = 24,
  parameter int ITER_PERIOD    = 48,
  parameter int ITER_CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_sched_loader_if.slave bus
);

  // Word/phase counters share one width; ITER_PERIOD is assumed >= 2.
  localparam int PW = (ITER_PERIOD > 1) ? $clog2(ITER_PERIOD) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(ITER_PERIOD - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(ITER_PERIOD - 2);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      r_s_ready;
  logic [PW-1:0]             r_wcnt;
  logic                      r_load_ctrl;
  logic [CTRL_WIDTH-1:0]     r_ctrl_in;
  logic                      r_sched_loaded;
  logic [PW-1:0]             r_phase;
  logic [ITER_CNT_WIDTH-1:0] r_iters;
  logic [ITER_CNT_WIDTH-1:0] r_iter_count;
  logic                      r_start_ctrl;
  logic                      r_stop_ctrl;
  logic                      r_iter_done;

  logic                      w_hs;
  logic                      w_last_word;
  logic                      w_in_run;
  logic                      w_run_go;
  logic                      w_armed_abort;
  logic                      w_run_abort;
  logic                      w_done_next;
  logic [ITER_CNT_WIDTH-1:0] w_iter_next;
  logic                      w_final_next;
  logic                      w_stop_next;

  assign w_hs          = bus.s_valid && r_s_ready;
  assign w_last_word   = w_hs && (r_wcnt == LAST_IDX);
  assign w_in_run      = (r_state == ST_RUN);
  assign w_run_go      = (r_state == ST_ARMED) && bus.cmd_run && !bus.cmd_abort;
  assign w_armed_abort = (r_state == ST_ARMED) && bus.cmd_abort;
  // Once a stop pulse is queued the run is over: later aborts and wraps are ignored.
  assign w_run_abort   = w_in_run && !r_stop_ctrl && bus.cmd_abort;
  // Outputs are registered, so the wrap is detected one phase early; an abort
  // in that same cycle suppresses the iter_done of the partial iteration.
  assign w_done_next   = w_in_run && !r_stop_ctrl && (r_phase == PRE_LAST) && !bus.cmd_abort;
  assign w_iter_next   = r_iter_count + ITER_CNT_WIDTH'(1);
  assign w_final_next  = w_done_next && (r_iters != '0) && (w_iter_next == r_iters);
  assign w_stop_next   = w_run_abort || w_final_next;

  // Next-state decode; in RUN the state leaves on the cycle the stop pulse is out.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:  if (w_last_word) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (bus.cmd_abort)    w_state_nxt = ST_LOAD;
        else if (bus.cmd_run) w_state_nxt = ST_RUN;
      end
      ST_RUN:   if (r_stop_ctrl) w_state_nxt = ST_ARMED;
      default:  w_state_nxt = ST_LOAD;
    endcase
  end

  // State register; s_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_LOAD;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == ST_LOAD);
    end
  end

  // Schedule load path: capture each accepted word and strobe it into the controller.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt         <= '0;
      r_load_ctrl    <= 1'b0;
      r_ctrl_in      <= '0;
      r_sched_loaded <= 1'b0;
    end else begin
      r_load_ctrl <= w_hs;
      if (w_hs) begin
        r_ctrl_in <= bus.s_data;
        r_wcnt    <= w_last_word ? '0 : r_wcnt + PW'(1);
      end
      if (w_last_word) begin
        r_sched_loaded <= 1'b1;
      end else if (w_armed_abort) begin
        r_sched_loaded <= 1'b0;
        r_wcnt         <= '0;
      end
    end
  end

  // Run sequencing: phase counter, iteration bookkeeping and start/stop/done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= '0;
      r_iters      <= '0;
      r_iter_count <= '0;
      r_start_ctrl <= 1'b0;
      r_stop_ctrl  <= 1'b0;
      r_iter_done  <= 1'b0;
    end else begin
      r_start_ctrl <= w_run_go;
      r_stop_ctrl  <= w_stop_next;
      r_iter_done  <= w_done_next;
      if (w_run_go) begin
        r_phase      <= '0;
        r_iters      <= bus.run_iters;
        r_iter_count <= '0;
      end else if (w_in_run) begin
        r_phase <= (r_phase == LAST_IDX) ? '0 : r_phase + PW'(1);
        if (w_done_next) begin
          r_iter_count <= w_iter_next;
        end
      end
    end
  end

  assign bus.s_ready      = r_s_ready;
  assign bus.load_ctrl    = r_load_ctrl;
  assign bus.ctrl_in      = r_ctrl_in;
  assign bus.start_ctrl   = r_start_ctrl;
  assign bus.stop_ctrl    = r_stop_ctrl;
  assign bus.sched_loaded = r_sched_loaded;
  assign bus.busy         = w_in_run;
  assign bus.iter_done    = r_iter_done;
  assign bus.iter_count   = r_iter_count;

endmodule
